// File: rtl/frequency_analyzer_array.sv
// rtl/frequency_analyzer_array.sv - N-channel pixel frequency analyzer with register-write result dump
module frequency_analyzer_array #(
    parameter int                     CHANNELS        = 3,
    parameter int                     DATA_WIDTH      = 8,
    parameter int                     LINE_WIDTH      = 1024,
    parameter logic [32*CHANNELS-1:0] PIXEL_INDICES   = {32'd1023, 32'd511, 32'd63},
    parameter logic [64*CHANNELS-1:0] FREQUENCIES     = {32'd30000, 32'd25000, 32'd20000,
                                                         32'd15000, 32'd10000, 32'd5000},
    parameter int                     THRESHOLD       = 192,
    parameter int                     DEVIATION_PCT   = 20,
    parameter int                     COUNT_WIDTH     = 32,
    parameter int                     CLOCK_FREQUENCY = 100000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  pixel_valid,
    input  logic                  line_start,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic                  reg_wr_valid,
    input  logic                  reg_wr_ready,
    output logic [7:0]            reg_wr_number,
    output logic [31:0]           reg_wr_data,
    output logic                  busy,
    output logic                  irq,
    input  logic                  irq_ack
);

    localparam int INDEX_WIDTH = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int WORDS       = 2 * CHANNELS;

    localparam logic [INDEX_WIDTH-1:0] LAST_COLUMN = INDEX_WIDTH'(LINE_WIDTH - 1);
    localparam logic [4:0]             LAST_WORD   = 5'(WORDS - 1);
    localparam logic [31:0]            THRESHOLD_U = 32'(THRESHOLD);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [INDEX_WIDTH-1:0] column_q, column_d;
    logic [CHANNELS-1:0]    sample_q, sample_d;
    logic [CHANNELS-1:0]    synced_q, synced_d;
    logic [COUNT_WIDTH-1:0] counter_q [CHANNELS];
    logic [COUNT_WIDTH-1:0] counter_d [CHANNELS];
    logic [COUNT_WIDTH-1:0] period_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] period_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] acc_f0_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] acc_f0_d  [CHANNELS];
    logic [COUNT_WIDTH-1:0] acc_f1_q  [CHANNELS];
    logic [COUNT_WIDTH-1:0] acc_f1_d  [CHANNELS];
    logic [4:0]             word_idx_q, word_idx_d;

    logic        reg_wr_valid_q, reg_wr_valid_d;
    logic [7:0]  reg_wr_number_q, reg_wr_number_d;
    logic [31:0] reg_wr_data_q, reg_wr_data_d;
    logic        busy_q, busy_d;
    logic        irq_q, irq_d;

    logic [INDEX_WIDTH-1:0] pixel_col;
    logic                   sample_in;
    logic [CHANNELS-1:0]    hit;
    logic [CHANNELS-1:0]    match_f0;
    logic [CHANNELS-1:0]    match_f1;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // A pixel flagged with line_start is column 0 regardless of the running count
    assign pixel_col = line_start ? '0 : column_q;
    assign sample_in = (32'(data) >= THRESHOLD_U);

    // Per-channel column hit and period match windows fixed at elaboration
    for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
        localparam logic [63:0] P_F0  = 64'(CLOCK_FREQUENCY) / 64'(FREQUENCIES[64*k +: 32]);
        localparam logic [63:0] P_F1  = 64'(CLOCK_FREQUENCY) / 64'(FREQUENCIES[64*k+32 +: 32]);
        localparam logic [63:0] DV_F0 = (P_F0 * 64'(DEVIATION_PCT)) / 64'd100;
        localparam logic [63:0] DV_F1 = (P_F1 * 64'(DEVIATION_PCT)) / 64'd100;
        localparam logic [63:0] LO_F0 = P_F0 - DV_F0;
        localparam logic [63:0] HI_F0 = P_F0 + DV_F0;
        localparam logic [63:0] LO_F1 = P_F1 - DV_F1;
        localparam logic [63:0] HI_F1 = P_F1 + DV_F1;

        assign hit[k]      = pixel_valid && (32'(pixel_col) == PIXEL_INDICES[32*k +: 32]);
        assign match_f0[k] = (64'(period_q[k]) >= LO_F0) && (64'(period_q[k]) <= HI_F0);
        assign match_f1[k] = (64'(period_q[k]) >= LO_F1) && (64'(period_q[k]) <= HI_F1);
    end

    // Next-state, measurement datapath and registered output values
    always_comb begin
        state_d         = state_q;
        column_d        = column_q;
        sample_d        = sample_q;
        synced_d        = synced_q;
        counter_d       = counter_q;
        period_d        = period_q;
        acc_f0_d        = acc_f0_q;
        acc_f1_d        = acc_f1_q;
        word_idx_d      = word_idx_q;
        reg_wr_valid_d  = 1'b0;
        reg_wr_number_d = '0;
        reg_wr_data_d   = '0;
        busy_d          = 1'b0;
        irq_d           = 1'b0;

        if (pixel_valid) begin
            column_d = (pixel_col == LAST_COLUMN) ? '0 : pixel_col + INDEX_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d    = S_DUMP;
                    word_idx_d = '0;
                end
            end
            S_DUMP: begin
                if (reg_wr_valid_q && reg_wr_ready) begin
                    if (word_idx_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                end else if (irq_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_RUN) begin
            for (int k = 0; k < CHANNELS; k++) begin
                counter_d[k] = sat_inc(counter_q[k]);
                if (hit[k]) begin
                    sample_d[k] = sample_in;
                    if (sample_in && !sample_q[k]) begin
                        // The first rising edge only aligns the counter; no period yet
                        counter_d[k] = '0;
                        synced_d[k]  = 1'b1;
                        if (synced_q[k]) begin
                            period_d[k] = sat_inc(counter_q[k]);
                        end
                    end
                end
                if (match_f0[k]) begin
                    acc_f0_d[k] = sat_inc(acc_f0_q[k]);
                end
                if (match_f1[k]) begin
                    acc_f1_d[k] = sat_inc(acc_f1_q[k]);
                end
            end
        end

        // Results must stay frozen while they are being written out
        if (clear && (state_q != S_DUMP)) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc_f0_d[k] = '0;
                acc_f1_d[k] = '0;
            end
        end

        if ((state_d == S_RUN) && (state_q != S_RUN)) begin
            column_d = '0;
            sample_d = '0;
            synced_d = '0;
            for (int k = 0; k < CHANNELS; k++) begin
                counter_d[k] = '0;
                period_d[k]  = '0;
                acc_f0_d[k]  = '0;
                acc_f1_d[k]  = '0;
            end
        end

        // Word i carries channel i/2, bin i%2; built from next-cycle accumulators
        if (state_d == S_DUMP) begin
            reg_wr_valid_d  = 1'b1;
            reg_wr_number_d = 8'(word_idx_d) + 8'd1;
            for (int k = 0; k < CHANNELS; k++) begin
                if (word_idx_d == 5'(2 * k)) begin
                    reg_wr_data_d = 32'(acc_f0_d[k]);
                end
                if (word_idx_d == 5'(2 * k + 1)) begin
                    reg_wr_data_d = 32'(acc_f1_d[k]);
                end
            end
        end

        busy_d = (state_d != S_IDLE);
        irq_d  = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            column_q        <= '0;
            sample_q        <= '0;
            synced_q        <= '0;
            counter_q       <= '{default: '0};
            period_q        <= '{default: '0};
            acc_f0_q        <= '{default: '0};
            acc_f1_q        <= '{default: '0};
            word_idx_q      <= '0;
            reg_wr_valid_q  <= 1'b0;
            reg_wr_number_q <= '0;
            reg_wr_data_q   <= '0;
            busy_q          <= 1'b0;
            irq_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            column_q        <= column_d;
            sample_q        <= sample_d;
            synced_q        <= synced_d;
            counter_q       <= counter_d;
            period_q        <= period_d;
            acc_f0_q        <= acc_f0_d;
            acc_f1_q        <= acc_f1_d;
            word_idx_q      <= word_idx_d;
            reg_wr_valid_q  <= reg_wr_valid_d;
            reg_wr_number_q <= reg_wr_number_d;
            reg_wr_data_q   <= reg_wr_data_d;
            busy_q          <= busy_d;
            irq_q           <= irq_d;
        end
    end

    assign reg_wr_valid  = reg_wr_valid_q;
    assign reg_wr_number = reg_wr_number_q;
    assign reg_wr_data   = reg_wr_data_q;
    assign busy          = busy_q;
    assign irq           = irq_q;

endmodule
